// File: rtl/reg_port_seq_if.sv
// Bundle of the writeback, operand-read, operand-out and register-file port signals.
// The master modport is the sequencer; the slave modport is its surroundings.
interface reg_port_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_srcA;
    logic [ADDR_W-1:0] rd_srcB;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic [ADDR_W-1:0] srcA;
    logic [ADDR_W-1:0] srcB;
    logic              RegWrite;
    logic [DATA_W-1:0] writeValue;
    logic [DATA_W-1:0] ReadA;
    logic [DATA_W-1:0] ReadB;

    modport master (
        input  wb_valid, wb_reg, wb_data,
        input  rd_valid, rd_srcA, rd_srcB,
        input  op_ready,
        input  ReadA, ReadB,
        output wb_ready, rd_ready,
        output op_valid, op_a, op_b,
        output srcA, srcB, RegWrite, writeValue
    );

    modport slave (
        output wb_valid, wb_reg, wb_data,
        output rd_valid, rd_srcA, rd_srcB,
        output op_ready,
        output ReadA, ReadB,
        input  wb_ready, rd_ready,
        input  op_valid, op_a, op_b,
        input  srcA, srcB, RegWrite, writeValue
    );
endinterface

// File: rtl/reg_port_seq.sv
// Register-file port sequencer: buffers writebacks in a FIFO and interleaves them with operand reads.
// Define REG_FWD_EN to forward pending writebacks to reads instead of stalling on hazards.
module reg_port_seq #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned WB_DEPTH = 2
) (
    input  logic           CLK,
    input  logic           RST,
    reg_port_seq_if.master bus
);
    localparam int unsigned PtrW = $clog2(WB_DEPTH);
    localparam logic [PtrW-1:0] PtrOne = 1;
    localparam logic [PtrW:0]   CntOne = 1;
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(WB_DEPTH);

    typedef enum logic [1:0] {ModeIdle, ModeRead, ModeWrite, ModeWriteFull} mode_e;

    logic [ADDR_W-1:0] fifo_reg_q  [WB_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [WB_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]     count_q;
    logic              op_valid_q;
    logic [DATA_W-1:0] op_a_q, op_b_q;

    mode_e             mode;
    logic              full, empty, out_free, push, pop, stall;
    logic              hit_a, hit_b, wb_hit_a, wb_hit_b;
    logic [PtrW-1:0]   idx;
    logic [DATA_W-1:0] rd_a, rd_b;
`ifdef REG_FWD_EN
    logic [DATA_W-1:0] fifo_a, fifo_b;
`endif

    assign full     = (count_q == CntFull);
    assign empty    = (count_q == '0);
    assign out_free = !op_valid_q || bus.op_ready;
    // A same-cycle writeback is older than the read it races with.
    assign wb_hit_a = bus.wb_valid && (bus.rd_srcA != '0) && (bus.wb_reg == bus.rd_srcA);
    assign wb_hit_b = bus.wb_valid && (bus.rd_srcB != '0) && (bus.wb_reg == bus.rd_srcB);

    // Walk entries oldest to youngest so the last match is the youngest.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx   = '0;
`ifdef REG_FWD_EN
        fifo_a = '0;
        fifo_b = '0;
`endif
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = rd_ptr_q + (PtrW)'(k);
            if ((PtrW + 1)'(k) < count_q) begin
                if ((bus.rd_srcA != '0) && (fifo_reg_q[idx] == bus.rd_srcA)) begin
                    hit_a = 1'b1;
`ifdef REG_FWD_EN
                    fifo_a = fifo_data_q[idx];
`endif
                end
                if ((bus.rd_srcB != '0) && (fifo_reg_q[idx] == bus.rd_srcB)) begin
                    hit_b = 1'b1;
`ifdef REG_FWD_EN
                    fifo_b = fifo_data_q[idx];
`endif
                end
            end
        end
    end

`ifdef REG_FWD_EN
    assign stall = 1'b0;
    assign rd_a  = (bus.rd_srcA == '0) ? '0 : wb_hit_a ? bus.wb_data : hit_a ? fifo_a : bus.ReadA;
    assign rd_b  = (bus.rd_srcB == '0) ? '0 : wb_hit_b ? bus.wb_data : hit_b ? fifo_b : bus.ReadB;
`else
    assign stall = hit_a || hit_b || wb_hit_a || wb_hit_b;
    assign rd_a  = (bus.rd_srcA == '0) ? '0 : bus.ReadA;
    assign rd_b  = (bus.rd_srcB == '0) ? '0 : bus.ReadB;
`endif

    always_comb begin
        mode = ModeIdle;
        if (RST) begin
            mode = ModeIdle;
        end else if (full) begin
            mode = ModeWriteFull;
        end else if (bus.rd_valid && out_free && !stall) begin
            mode = ModeRead;
        end else if (!empty) begin
            mode = ModeWrite;
        end
    end

    assign pop          = (mode == ModeWrite) || (mode == ModeWriteFull);
    assign push         = bus.wb_valid && bus.wb_ready && (bus.wb_reg != '0);
    assign bus.wb_ready = !RST && !full;
    assign bus.rd_ready = (mode == ModeRead);
    assign bus.RegWrite = pop;
    assign bus.op_valid = op_valid_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;

    always_comb begin
        bus.srcA       = '0;
        bus.srcB       = '0;
        bus.writeValue = '0;
        unique case (mode)
            ModeRead: begin
                bus.srcA = bus.rd_srcA;
                bus.srcB = bus.rd_srcB;
            end
            ModeWrite, ModeWriteFull: begin
                bus.srcA       = fifo_reg_q[rd_ptr_q];
                bus.writeValue = fifo_data_q[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push && !pop) begin
                count_q <= count_q + CntOne;
            end else if (pop && !push) begin
                count_q <= count_q - CntOne;
            end
            if (mode == ModeRead) begin
                op_valid_q <= 1'b1;
                op_a_q     <= rd_a;
                op_b_q     <= rd_b;
            end else if (bus.op_ready) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= bus.wb_reg;
            fifo_data_q[wr_ptr_q] <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_reg_port_seq.sv
// Directed bench for reg_port_seq with a behavioural register file on the port.
// Expectations for the REG_FWD_EN build are selected with the same macro.
module tb_reg_port_seq;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   base;

    reg_port_seq_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    reg_port_seq #(.DATA_W(16), .ADDR_W(3), .WB_DEPTH(2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [15:0] rf      [8];
    logic [2:0]  log_reg [32];
    logic [15:0] log_val [32];
    int          wr_cnt;

    // Register file: R2 holds 2, others 0x0F00+index so R0 reads are visibly nonzero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= (i == 2) ? 16'h0002 : 16'h0F00 + 16'(i);
            wr_cnt <= 0;
        end else if (bus.RegWrite) begin
            rf[bus.srcA]           <= bus.writeValue;
            log_reg[wr_cnt[4:0]]   <= bus.srcA;
            log_val[wr_cnt[4:0]]   <= bus.writeValue;
            wr_cnt                 <= wr_cnt + 1;
        end
    end
    assign bus.ReadA = rf[bus.srcA];
    assign bus.ReadB = rf[bus.srcB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        base  = 0;
        rst   = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
        bus.rd_valid = 1'b0; bus.rd_srcA = '0; bus.rd_srcB = '0;
        bus.op_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("rst_regwrite", 32'(bus.RegWrite), 0);
        check("rst_op_valid", 32'(bus.op_valid), 0);
        check("rst_op_a", 32'(bus.op_a), 0);
        check("rst_op_b", 32'(bus.op_b), 0);
        check("rst_srcA", 32'(bus.srcA), 0);
        check("rst_srcB", 32'(bus.srcB), 0);
        check("rst_writeValue", 32'(bus.writeValue), 0);
        tick(); tick();
        rst = 1'b0;
        #2 check("rel_wb_ready", 32'(bus.wb_ready), 1);

        // Reset mid-operation: operands held, one write draining.
        bus.op_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_srcA = 3'd2; bus.rd_srcB = 3'd1;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd4; bus.wb_data = 16'h1111;
        #2 check("t1_rd_ready", 32'(bus.rd_ready), 1);
        tick();
        bus.rd_valid = 1'b0; bus.wb_valid = 1'b0;
        #2;
        check("t1_op_a_held", 32'(bus.op_a), 2);
        check("t1_regwrite_pre", 32'(bus.RegWrite), 1);
        check("t1_srcA_pre", 32'(bus.srcA), 4);
        rst = 1'b1;
        #1;
        check("t1_regwrite_rst", 32'(bus.RegWrite), 0);
        check("t1_op_valid_rst", 32'(bus.op_valid), 0);
        check("t1_op_a_rst", 32'(bus.op_a), 0);
        tick();
        rst = 1'b0; bus.op_ready = 1'b1;
        #2 check("t1_wb_ready", 32'(bus.wb_ready), 1);
        tick(); tick();
        check("t1_regwrite_after", 32'(bus.RegWrite), 0);
        check("t1_no_writes", 32'(wr_cnt), 0);

        // Write then read of the same register.
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd3; bus.wb_data = 16'h0003;
        #2 check("t2_wb_ready", 32'(bus.wb_ready), 1);
        tick();
        bus.wb_valid = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_srcA = 3'd3; bus.rd_srcB = 3'd0;
        #2;
`ifdef REG_FWD_EN
        check("t2_rd_ready", 32'(bus.rd_ready), 1);
        tick();
        bus.rd_valid = 1'b0;
        #2;
        check("t2_op_valid", 32'(bus.op_valid), 1);
        check("t2_op_a", 32'(bus.op_a), 'h0003);
        check("t2_op_b", 32'(bus.op_b), 0);
        check("t2_drain", 32'(bus.RegWrite), 1);
        check("t2_drain_srcA", 32'(bus.srcA), 3);
`else
        check("t2_rd_stall", 32'(bus.rd_ready), 0);
        check("t2_regwrite", 32'(bus.RegWrite), 1);
        check("t2_srcA_wr", 32'(bus.srcA), 3);
        check("t2_writeValue", 32'(bus.writeValue), 'h0003);
        tick();
        #2;
        check("t2_rd_ready", 32'(bus.rd_ready), 1);
        check("t2_regwrite_rd", 32'(bus.RegWrite), 0);
        check("t2_srcA_rd", 32'(bus.srcA), 3);
        tick();
        bus.rd_valid = 1'b0;
        #2;
        check("t2_op_valid", 32'(bus.op_valid), 1);
        check("t2_op_a", 32'(bus.op_a), 'h0003);
        check("t2_op_b", 32'(bus.op_b), 0);
`endif
        tick();

        // Same-cycle writeback and read of R5.
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd5; bus.wb_data = 16'h0055;
        bus.rd_valid = 1'b1; bus.rd_srcA = 3'd5; bus.rd_srcB = 3'd5;
        #2;
`ifdef REG_FWD_EN
        check("t3_rd_ready", 32'(bus.rd_ready), 1);
        tick();
        bus.wb_valid = 1'b0; bus.rd_valid = 1'b0;
        #2;
        check("t3_op_a", 32'(bus.op_a), 'h0055);
        check("t3_op_b", 32'(bus.op_b), 'h0055);
        check("t3_drain_srcA", 32'(bus.srcA), 5);
`else
        check("t3_rd_stall0", 32'(bus.rd_ready), 0);
        check("t3_regwrite0", 32'(bus.RegWrite), 0);
        tick();
        bus.wb_valid = 1'b0;
        #2;
        check("t3_rd_stall1", 32'(bus.rd_ready), 0);
        check("t3_regwrite1", 32'(bus.RegWrite), 1);
        check("t3_srcA_wr", 32'(bus.srcA), 5);
        check("t3_writeValue", 32'(bus.writeValue), 'h0055);
        tick();
        #2 check("t3_rd_ready", 32'(bus.rd_ready), 1);
        tick();
        bus.rd_valid = 1'b0;
        #2;
        check("t3_op_valid", 32'(bus.op_valid), 1);
        check("t3_op_a", 32'(bus.op_a), 'h0055);
        check("t3_op_b", 32'(bus.op_b), 'h0055);
`endif
        tick();

        // FIFO fills under continuous non-hazard reads.
        base = wr_cnt;
        bus.rd_valid = 1'b1; bus.rd_srcA = 3'd1; bus.rd_srcB = 3'd2;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd4; bus.wb_data = 16'h0004;
        #2 check("t4_rd_ready0", 32'(bus.rd_ready), 1);
        tick();
        bus.wb_reg = 3'd6; bus.wb_data = 16'h0006;
        #2 check("t4_wb_ready1", 32'(bus.wb_ready), 1);
        tick();
        bus.wb_reg = 3'd7; bus.wb_data = 16'h0007;
        #2;
        check("t4_full_wb_ready", 32'(bus.wb_ready), 0);
        check("t4_full_rd_ready", 32'(bus.rd_ready), 0);
        check("t4_full_regwrite", 32'(bus.RegWrite), 1);
        check("t4_full_srcA", 32'(bus.srcA), 4);
        check("t4_op_a", 32'(bus.op_a), 'h0F01);
        check("t4_op_b", 32'(bus.op_b), 'h0002);
        tick();
        #2;
        check("t4_wb_ready_again", 32'(bus.wb_ready), 1);
        check("t4_rd_ready_again", 32'(bus.rd_ready), 1);
        tick();
        bus.wb_valid = 1'b0;
        #2 check("t4_full2_srcA", 32'(bus.srcA), 6);
        tick();
        bus.rd_valid = 1'b0;
        #2 check("t4_last_srcA", 32'(bus.srcA), 7);
        tick();
        check("t4_wr_cnt", 32'(wr_cnt), 32'(base + 3));
        check("t4_order0", 32'(log_reg[base]), 4);
        check("t4_order1", 32'(log_reg[base + 1]), 6);
        check("t4_order2", 32'(log_reg[base + 2]), 7);
        check("t4_val2", 32'(log_val[base + 2]), 'h0007);

        // R0 writes are dropped and R0 reads as zero.
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd0; bus.wb_data = 16'hABCD;
        #2 check("t5_wb_ready", 32'(bus.wb_ready), 1);
        tick();
        bus.wb_valid = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_srcA = 3'd0; bus.rd_srcB = 3'd0;
        #2;
        check("t5_rd_ready", 32'(bus.rd_ready), 1);
        check("t5_regwrite", 32'(bus.RegWrite), 0);
        tick();
        bus.rd_valid = 1'b0;
        #2;
        check("t5_op_valid", 32'(bus.op_valid), 1);
        check("t5_op_a", 32'(bus.op_a), 0);
        check("t5_op_b", 32'(bus.op_b), 0);
        tick();
        check("t5_wr_cnt", 32'(wr_cnt), 32'(base + 3));

        // Backpressure: operands hold while a queued write drains.
        bus.op_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_srcA = 3'd2; bus.rd_srcB = 3'd1;
        bus.wb_valid = 1'b1; bus.wb_reg = 3'd4; bus.wb_data = 16'h0444;
        #2 check("t6_rd_ready0", 32'(bus.rd_ready), 1);
        tick();
        bus.wb_valid = 1'b0;
        #2;
        check("t6_op_valid", 32'(bus.op_valid), 1);
        check("t6_op_a_c1", 32'(bus.op_a), 'h0002);
        check("t6_op_b_c1", 32'(bus.op_b), 'h0F01);
        check("t6_rd_ready_c1", 32'(bus.rd_ready), 0);
        check("t6_drain_c1", 32'(bus.RegWrite), 1);
        check("t6_drain_srcA", 32'(bus.srcA), 4);
        tick();
        #2;
        check("t6_op_a_c2", 32'(bus.op_a), 'h0002);
        check("t6_rd_ready_c2", 32'(bus.rd_ready), 0);
        check("t6_idle_c2", 32'(bus.RegWrite), 0);
        tick();
        #2;
        check("t6_op_a_c3", 32'(bus.op_a), 'h0002);
        check("t6_rd_ready_c3", 32'(bus.rd_ready), 0);
        bus.op_ready = 1'b1; bus.rd_srcA = 3'd3; bus.rd_srcB = 3'd5;
        #2 check("t6_reissue", 32'(bus.rd_ready), 1);
        tick();
        bus.rd_valid = 1'b0;
        #2;
        check("t6_op_valid_kept", 32'(bus.op_valid), 1);
        check("t6_op_a_new", 32'(bus.op_a), 'h0003);
        check("t6_op_b_new", 32'(bus.op_b), 'h0055);
        tick();
        check("t6_op_valid_clr", 32'(bus.op_valid), 0);
        check("t6_wr_val", 32'(log_val[base + 3]), 'h0444);
        check("t6_wr_cnt", 32'(wr_cnt), 32'(base + 4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_port_seq.md
Name: reg_port_seq

Overview:
- Initiator side of the CPU register file port. It owns srcA, srcB, RegWrite and writeValue, and consumes ReadA and ReadB.
- The register file writes at the address on srcA, so a writeback and an operand read cannot share a cycle. This block arbitrates between them.
- Writebacks from the execute stage are buffered in a small FIFO. Operand reads from decode are issued and registered toward the ALU.
- RAW ordering is kept by hazard stalls, or by forwarding when the optional feature is compiled in.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register index width (8 registers).
- WB_DEPTH, 2, writeback FIFO entries; power of 2, at least 2.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous reset, active-high.
- wb_valid  in  1  writeback request valid.
- wb_ready  out  1  writeback accepted when wb_valid && wb_ready.
- wb_reg  in  ADDR_W  destination register.
- wb_data  in  DATA_W  writeback value.
- rd_valid  in  1  operand read request valid.
- rd_ready  out  1  read accepted when rd_valid && rd_ready.
- rd_srcA  in  ADDR_W  operand A register.
- rd_srcB  in  ADDR_W  operand B register.
- op_valid  out  1  operands valid.
- op_ready  in  1  ALU consumes operands.
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- srcA  out  ADDR_W  to register file; read address A, and also the write address.
- srcB  out  ADDR_W  to register file; read address B.
- RegWrite  out  1  register file write enable; the write commits on posedge CLK.
- writeValue  out  DATA_W  register file write data.
- ReadA  in  DATA_W  combinational read data for srcA.
- ReadB  in  DATA_W  combinational read data for srcB.

Behaviour:
- Reset values, applied asynchronously on RST=1:
  - FIFO empty; op_valid=0; op_a=op_b=0.
  - RegWrite=0; srcA=srcB=0; writeValue=0.
  - wb_ready=1 once RST deasserts.
  - A reset mid-operation discards pending writes and the held operands.
- Writeback FIFO:
  - wb_ready = !full.
  - An accepted write with wb_reg==0 is dropped and never enqueued; R0 is the zero register.
  - Enqueue and dequeue in the same cycle are both allowed; count is unchanged.
- Output register is free when op_valid==0 or op_ready==1.
- Hazard: rd_srcA or rd_srcB is nonzero and equals the reg of any FIFO entry, or equals wb_reg while wb_valid is high in the same cycle (a write is older than a same-cycle read).
- Each cycle performs exactly one mode, chosen in priority order:
  1. WRITE_FULL: FIFO full → drain the head; rd_ready=0.
  2. READ: rd_valid && output free && no hazard → rd_ready=1, RegWrite=0, srcA=rd_srcA, srcB=rd_srcB.
     - On the edge: op_a <= (rd_srcA==0 ? 0 : ReadA); op_b likewise from rd_srcB and ReadB; op_valid <= 1.
     - Latency: accept edge to op_valid is 1 cycle.
  3. WRITE: FIFO non-empty → RegWrite=1, srcA=head.reg, writeValue=head.data, srcB=0; pop on the edge; rd_ready=0.
  4. IDLE: RegWrite=0, srcA=srcB=0, writeValue=0.
- Drain latency: an enqueued write reaches the register file no earlier than the cycle after it is accepted.
- op_valid && !op_ready: op_a and op_b hold stable; no read is issued; writes still drain.
- op_valid clears on op_ready unless a new read is accepted in the same cycle.
- FIFO pointers wrap modulo WB_DEPTH.

Optional Feature:
Macro REG_FWD_EN.
- Defined:
  - A hazard does not stall the read.
  - Each matching operand takes the youngest matching value: same-cycle wb_data first, then the youngest FIFO entry, otherwise the register file.
  - The FIFO still drains the entry to the register file later.
- Undefined:
  - Hazard reads stall (rd_ready=0) until the matching entries have drained.

Test Plan:
1. Reset: RST=1 while RegWrite is pulsing with 1 entry queued → RegWrite=0 and op_valid=0 immediately; after release, wb_ready=1 and no write ever appears.
2. Write then read: wb(R3,0x0003), then next cycle rd(3,0) →
   - Without REG_FWD_EN: RegWrite=1 with srcA=3 and writeValue=0x0003 first, then the read is issued, then op_a=0x0003, op_b=0x0000.
   - With REG_FWD_EN: the read is accepted without stall; op_a=0x0003.
3. Same-cycle hazard: wb(R5,0x0055) and rd(5,5) in one cycle →
   - Without REG_FWD_EN: rd_ready=0 until the write commits; op_a=op_b=0x0055.
   - With REG_FWD_EN: op_a=op_b=0x0055 one cycle later.
4. FIFO full with WB_DEPTH=2: continuous non-hazard reads of (1,2), writes R4=0x0004, R6=0x0006, R7=0x0007 back-to-back → wb_ready=0 after 2 entries, one WRITE_FULL cycle with srcA=4 and rd_ready=0, then wb_ready=1; all three writes commit in order 4, 6, 7.
5. Zero register: wb(R0,0xABCD) then rd(0,0) → RegWrite never asserts for R0; op_a=op_b=0.
6. Backpressure: op_ready=0 for 3 cycles after op_valid with op_a=0x0002 → op_a stable at 0x0002 and rd_ready=0 throughout; a queued write still drains during the stall.
